mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single backing memory port between the instruction-fetch requester (stage 1 / IF) and the data requester (MEM stage).
- Fixed priority goes to data, with a starvation guard so fetch cannot be locked out.
- Uses a req/ack handshake on both sides and tolerates variable memory latency.
- Sits between the pipeline stages and memory_controller.

Parameters:
- ADDR_W, 32, address width for both requesters and memory.
- DATA_W, 32, data width.
- STARVE_MAX, 4, max consecutive data grants while a fetch is pending; must be ≥1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-low
- d_req  input  1  data request; held until d_ack
- d_we  input  1  data write (1) / read (0); stable while d_req
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  store data
- d_rdata  output  DATA_W  load data; valid when d_ack
- d_ack  output  1  one-cycle completion pulse to data requester
- i_req  input  1  fetch request; held until i_ack
- i_addr  input  ADDR_W  fetch address (PC)
- i_rdata  output  DATA_W  instruction word; valid when i_ack
- i_ack  output  1  one-cycle completion pulse to fetch requester
- m_req  output  1  memory request; held until m_ack
- m_we  output  1  memory write enable
- m_addr  output  ADDR_W  memory address
- m_wdata  output  DATA_W  memory write data
- m_rdata  input  DATA_W  memory read data; valid with m_ack
- m_ack  input  1  memory completion, one cycle

Behaviour:
- Reset (rst=0, async) sets:
  - state=IDLE, owner=NONE, starve_cnt=0
  - m_req=0, m_we=0, m_addr=0, m_wdata=0
  - d_ack=0, i_ack=0, d_rdata=0, i_rdata=0
  - Any in-flight transaction is abandoned; the memory side must drop it.
- All outputs are registered.
- FSM states: IDLE, BUSY, DONE.
- IDLE: arbitrate on sampled d_req and i_req.
  - Neither asserted: stay in IDLE.
  - Only one asserted: grant it.
  - Both asserted: grant data unless starve_cnt==STARVE_MAX, then grant fetch.
  - On grant: latch owner, m_addr, m_we (0 for fetch), m_wdata; set m_req=1; go to BUSY.
- BUSY: hold m_req and the latched fields stable.
  - On m_ack: m_req=0; capture m_rdata into owner's rdata (data reads and fetches only; on a data write d_rdata keeps its old value); go to DONE.
- DONE: owner's ack=1 for exactly this cycle, other ack=0; then go to IDLE.
- Latency: request sampled in IDLE at cycle T; m_req high at T+1; m_ack at T+k (k≥1) gives ack at T+k+1. Minimum is 2 cycles req→ack, at most one transaction per 3 cycles.
- Requesters may drop req the cycle after ack. A req still high in the following IDLE is treated as a new request.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) on each data grant made while i_req=1.
  - Cleared on a fetch grant, or on any IDLE cycle with i_req=0.
- Boundary rules:
  - m_ack in IDLE or DONE is ignored.
  - Requester inputs changing during BUSY are ignored (fields are latched).
  - d_req and i_req together with starve_cnt<STARVE_MAX: data wins and fetch waits with i_ack=0 (fetch stall).
  - STARVE_MAX=1 gives strict alternation under continuous contention.
- Never both acks high; m_req never high outside BUSY.

Optional Feature:
- MEM_ARB_PERF_EN defined:
  - Adds outputs d_wait_cnt[31:0] and i_wait_cnt[31:0], reset to 0.
  - Each increments (wrapping) on every cycle its req=1 and its ack=0.
  - Also adds grant_cnt[31:0], incremented on each IDLE→BUSY transition.
- MEM_ARB_PERF_EN not defined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - owner encoding (NONE=2'd0, DATA=2'd1, INSTR=2'd2)
  - default STARVE_MAX.
- Sub-module mem_arb_prio holds the winner-select logic plus the starve_cnt register.
  - Inputs: d_req, i_req, grant strobe.
  - Output: winner.
- The top module holds the FSM and the datapath latches.

Test Plan:
- Reset mid-BUSY: fetch of 0x00000010 granted, rst low at T+2 → m_req, i_ack, i_rdata all 0 immediately; state IDLE after release.
- Lone fetch: i_req, i_addr=0x00000004, m_ack at T+1 with m_rdata=0x00500093 → m_addr=0x4 and m_we=0 at T+1; i_ack=1 with i_rdata=0x00500093 at T+2 only.
- Data store: d_req, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, m_ack after 3 cycles → m_we=1, m_wdata=0xDEADBEEF; d_ack pulses once; d_rdata unchanged.
- Contention: d_req and i_req held continuously, STARVE_MAX=4 → grant order D,D,D,D,I repeating; never two acks in one cycle.
- Spurious m_ack in IDLE with m_rdata=0xFFFFFFFF → no ack pulse, rdata registers unchanged.
- MEM_ARB_PERF_EN: fetch blocked by a 5-cycle data transaction → i_wait_cnt increases by the exact number of i_req-high, i_ack-low cycles; grant_cnt=2.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, owner codes and
// the default starvation limit.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_DATA  = 2'd1,
        OWN_INSTR = 2'd2
    } owner_t;

    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select for the memory arbiter: data has fixed priority, but once
// STARVE_MAX data grants have been made back-to-back against a waiting fetch,
// the fetch wins the next contended arbitration.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   idle,
    input  logic   grant,
    input  logic   d_req,
    input  logic   i_req,
    output owner_t winner
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_r;
    logic             starved_s;

    assign starved_s = (starve_cnt_r == CNT_W'(STARVE_MAX));

    // Pick the requester that would be granted if the FSM grants this cycle.
    always_comb begin
        winner = OWN_NONE;
        if (d_req && !(i_req && starved_s)) begin
            winner = OWN_DATA;
        end else if (i_req) begin
            winner = OWN_INSTR;
        end else begin
            winner = OWN_NONE;
        end
    end

    // Count data grants made while a fetch waits; clear when fetch is served or absent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (grant && (winner == OWN_INSTR)) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (grant && (winner == OWN_DATA) && i_req) begin
            if (!starved_s) begin
                starve_cnt_r <= starve_cnt_r + CNT_W'(1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else if (idle && !i_req) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the data
// stage. One transaction at a time: IDLE (arbitrate) -> BUSY (wait m_ack)
// -> DONE (one-cycle ack to the owner). All outputs are registered.
// Optional build macro MEM_ARB_PERF_EN adds wait-cycle and grant counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       d_wait_cnt,
    output logic [31:0]       i_wait_cnt,
    output logic [31:0]       grant_cnt
`endif
);

    state_t            state_r, state_nxt_s;
    owner_t            owner_r, owner_nxt_s;
    owner_t            winner_s;
    logic              grant_s;
    logic              idle_s;
    logic              m_req_nxt_s, m_we_nxt_s, d_ack_nxt_s, i_ack_nxt_s;
    logic [ADDR_W-1:0] m_addr_nxt_s;
    logic [DATA_W-1:0] m_wdata_nxt_s, d_rdata_nxt_s, i_rdata_nxt_s;

    assign idle_s = (state_r == ST_IDLE);

    mem_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk   (clk),
        .rst   (rst),
        .idle  (idle_s),
        .grant (grant_s),
        .d_req (d_req),
        .i_req (i_req),
        .winner(winner_s)
    );

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_nxt_s   = state_r;
        owner_nxt_s   = owner_r;
        grant_s       = 1'b0;
        m_req_nxt_s   = m_req;
        m_we_nxt_s    = m_we;
        m_addr_nxt_s  = m_addr;
        m_wdata_nxt_s = m_wdata;
        d_ack_nxt_s   = 1'b0;
        i_ack_nxt_s   = 1'b0;
        d_rdata_nxt_s = d_rdata;
        i_rdata_nxt_s = i_rdata;
        case (state_r)
            ST_IDLE: begin
                if (winner_s == OWN_DATA) begin
                    grant_s       = 1'b1;
                    owner_nxt_s   = OWN_DATA;
                    m_req_nxt_s   = 1'b1;
                    m_we_nxt_s    = d_we;
                    m_addr_nxt_s  = d_addr;
                    m_wdata_nxt_s = d_wdata;
                    state_nxt_s   = ST_BUSY;
                end else if (winner_s == OWN_INSTR) begin
                    grant_s       = 1'b1;
                    owner_nxt_s   = OWN_INSTR;
                    m_req_nxt_s   = 1'b1;
                    m_we_nxt_s    = 1'b0;
                    m_addr_nxt_s  = i_addr;
                    m_wdata_nxt_s = {DATA_W{1'b0}};
                    state_nxt_s   = ST_BUSY;
                end else begin
                    owner_nxt_s   = OWN_NONE;
                end
            end
            ST_BUSY: begin
                if (m_ack) begin
                    m_req_nxt_s = 1'b0;
                    state_nxt_s = ST_DONE;
                    if (owner_r == OWN_DATA) begin
                        d_ack_nxt_s = 1'b1;
                        if (!m_we) begin
                            d_rdata_nxt_s = m_rdata;
                        end else begin
                            d_rdata_nxt_s = d_rdata;
                        end
                    end else if (owner_r == OWN_INSTR) begin
                        i_ack_nxt_s   = 1'b1;
                        i_rdata_nxt_s = m_rdata;
                    end else begin
                        d_ack_nxt_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                m_req_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered datapath latches and handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_r <= OWN_NONE;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= {ADDR_W{1'b0}};
            m_wdata <= {DATA_W{1'b0}};
            d_ack   <= 1'b0;
            i_ack   <= 1'b0;
            d_rdata <= {DATA_W{1'b0}};
            i_rdata <= {DATA_W{1'b0}};
        end else begin
            owner_r <= owner_nxt_s;
            m_req   <= m_req_nxt_s;
            m_we    <= m_we_nxt_s;
            m_addr  <= m_addr_nxt_s;
            m_wdata <= m_wdata_nxt_s;
            d_ack   <= d_ack_nxt_s;
            i_ack   <= i_ack_nxt_s;
            d_rdata <= d_rdata_nxt_s;
            i_rdata <= i_rdata_nxt_s;
        end
    end

`ifdef MEM_ARB_PERF_EN
    // Wait-cycle and grant counters, wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_wait_cnt <= 32'd0;
            i_wait_cnt <= 32'd0;
            grant_cnt  <= 32'd0;
        end else begin
            if (d_req && !d_ack) begin
                d_wait_cnt <= d_wait_cnt + 32'd1;
            end else begin
                d_wait_cnt <= d_wait_cnt;
            end
            if (i_req && !i_ack) begin
                i_wait_cnt <= i_wait_cnt + 32'd1;
            end else begin
                i_wait_cnt <= i_wait_cnt;
            end
            if (grant_s) begin
                grant_cnt <= grant_cnt + 32'd1;
            end else begin
                grant_cnt <= grant_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = 32'd0, d_wdata = 32'd0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = 32'd0;
    logic        m_ack = 1'b0;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] d_wait_cnt, i_wait_cnt, grant_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack)
`ifdef MEM_ARB_PERF_EN
        , .d_wait_cnt(d_wait_cnt), .i_wait_cnt(i_wait_cnt), .grant_cnt(grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        d_req = 1'b0; i_req = 1'b0; m_ack = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic wait_mreq();
        int n;
        n = 0;
        while (!m_req && n < 20) begin
            tick();
            n++;
        end
        check_val("mreq_wait", m_req, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_i;
        // Reset state
        #2 rst = 1'b0;
        #1;
        check_val("rst_mreq", m_req, 32'd0);
        check_val("rst_mwe", m_we, 32'd0);
        check_val("rst_maddr", m_addr, 32'd0);
        check_val("rst_mwdata", m_wdata, 32'd0);
        check_val("rst_dack", d_ack, 32'd0);
        check_val("rst_iack", i_ack, 32'd0);
        check_val("rst_drdata", d_rdata, 32'd0);
        check_val("rst_irdata", i_rdata, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Lone fetch, single-cycle memory
        i_req = 1'b1; i_addr = 32'h0000_0004;
        tick();
        check_val("if_mreq", m_req, 32'd1);
        check_val("if_maddr", m_addr, 32'h0000_0004);
        check_val("if_mwe", m_we, 32'd0);
        check_val("if_iack_early", i_ack, 32'd0);
        m_ack = 1'b1; m_rdata = 32'h0050_0093;
        tick();
        m_ack = 1'b0;
        check_val("if_iack", i_ack, 32'd1);
        check_val("if_irdata", i_rdata, 32'h0050_0093);
        check_val("if_dack", d_ack, 32'd0);
        check_val("if_mreq_done", m_req, 32'd0);
        i_req = 1'b0;
        tick();
        check_val("if_iack_pulse", i_ack, 32'd0);

        // Reset in the middle of a BUSY fetch
        i_req = 1'b1; i_addr = 32'h0000_0010;
        tick();
        tick();
        check_val("rb_busy", m_req, 32'd1);
        rst = 1'b0;
        #1;
        check_val("rb_mreq", m_req, 32'd0);
        check_val("rb_iack", i_ack, 32'd0);
        check_val("rb_irdata", i_rdata, 32'd0);
        i_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_val("rb_state", 32'(dut.state_r), 32'(ST_IDLE));
        check_val("rb_mreq_after", m_req, 32'd0);

        // Data read to preload d_rdata
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0080;
        tick();
        m_ack = 1'b1; m_rdata = 32'hCAFE_F00D;
        tick();
        m_ack = 1'b0;
        check_val("rd_dack", d_ack, 32'd1);
        check_val("rd_drdata", d_rdata, 32'hCAFE_F00D);
        d_req = 1'b0;
        tick();

        // Data store with three BUSY cycles; inputs change while BUSY
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
        tick();
        check_val("st_mreq", m_req, 32'd1);
        check_val("st_mwe", m_we, 32'd1);
        check_val("st_maddr", m_addr, 32'h0000_0100);
        check_val("st_mwdata", m_wdata, 32'hDEAD_BEEF);
        d_wdata = 32'h0000_0000; d_addr = 32'h0000_0999; d_we = 1'b0;
        tick();
        tick();
        check_val("st_hold_wdata", m_wdata, 32'hDEAD_BEEF);
        check_val("st_hold_addr", m_addr, 32'h0000_0100);
        check_val("st_hold_we", m_we, 32'd1);
        check_val("st_dack_early", d_ack, 32'd0);
        m_ack = 1'b1; m_rdata = 32'h1234_5678;
        tick();
        m_ack = 1'b0;
        check_val("st_dack", d_ack, 32'd1);
        check_val("st_drdata_kept", d_rdata, 32'hCAFE_F00D);
        d_req = 1'b0;
        tick();
        check_val("st_dack_pulse", d_ack, 32'd0);

        // Spurious m_ack while IDLE
        m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        m_ack = 1'b0;
        check_val("sp_dack", d_ack, 32'd0);
        check_val("sp_iack", i_ack, 32'd0);
        check_val("sp_drdata", d_rdata, 32'hCAFE_F00D);
        check_val("sp_irdata", i_rdata, 32'd0);
        check_val("sp_mreq", m_req, 32'd0);

        // Continuous contention: D,D,D,D,I repeating
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
        i_req = 1'b1; i_addr = 32'h0000_0040;
        for (int k = 0; k < 10; k++) begin
            wait_mreq();
            exp_i = ((k % 5) == 4);
            check_val($sformatf("ct_addr%0d", k), m_addr, exp_i ? 32'h0000_0040 : 32'h0000_0300);
            m_ack = 1'b1; m_rdata = 32'(k);
            tick();
            m_ack = 1'b0;
            check_val($sformatf("ct_dack%0d", k), d_ack, 32'(!exp_i));
            check_val($sformatf("ct_iack%0d", k), i_ack, 32'(exp_i));
            check_val($sformatf("ct_both%0d", k), d_ack & i_ack, 32'd0);
            tick();
        end
        d_req = 1'b0; i_req = 1'b0;
        tick();
        tick();
        check_val("ct_idle_mreq", m_req, 32'd0);

`ifdef MEM_ARB_PERF_EN
        // Fetch blocked behind a 5-BUSY-cycle data read
        do_reset();
        check_val("pf_rst_iwait", i_wait_cnt, 32'd0);
        check_val("pf_rst_grant", grant_cnt, 32'd0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
        i_req = 1'b1; i_addr = 32'h0000_0020;
        tick();
        tick();
        tick();
        tick();
        tick();
        check_val("pf_dbusy", m_addr, 32'h0000_0200);
        m_ack = 1'b1; m_rdata = 32'h0000_AAAA;
        tick();
        m_ack = 1'b0;
        check_val("pf_dack", d_ack, 32'd1);
        d_req = 1'b0;
        tick();
        tick();
        check_val("pf_iaddr", m_addr, 32'h0000_0020);
        m_ack = 1'b1; m_rdata = 32'h0000_BBBB;
        tick();
        m_ack = 1'b0;
        check_val("pf_iack", i_ack, 32'd1);
        i_req = 1'b0;
        tick();
        check_val("pf_iwait", i_wait_cnt, 32'd9);
        check_val("pf_dwait", d_wait_cnt, 32'd6);
        check_val("pf_grant", grant_cnt, 32'd2);
`else
        do_reset();
        check_val("final_rst_mreq", m_req, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
